// File: rtl/camera_if_pkg.sv
// Shared definitions for the camera control register block: register
// offsets, STATUS/CONTROL bit positions and the capture sequencer states.
package camera_if_pkg;

  localparam logic [1:0] OFS_ADDR    = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_CONTROL = 2'd2;
  localparam logic [1:0] OFS_VERSION = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;

  localparam int CT_GO     = 0;
  localparam int CT_CONT   = 1;
  localparam int CT_IRQ_EN = 2;
  localparam int CT_ABORT  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } cap_state_t;

endpackage

// File: rtl/camera_ctrl_regs.sv
// Avalon-MM register responder for the camera s1 port plus the frame-capture
// sequencer that arms the capture engine one frame at a time.
// Optional feature macro: CAMERA_CTRL_IRQ_EN (registered level interrupt
// and a stored CONTROL[2]); when undefined irq is tied low.
module camera_ctrl_regs
  import camera_if_pkg::*;
#(
  parameter int          FCNT_W  = 16,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic        avs_s1_clk,
  input  logic        avs_s1_reset_n,
  input  logic [1:0]  avs_s1_address,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic        cap_start,
  output logic [31:0] cap_addr,
  output logic        cap_abort,
  input  logic        cap_busy,
  input  logic        cap_done,
  input  logic        cap_ovf,
  output logic        irq
);

  cap_state_t         r_state, w_state_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        r_cap_addr;
  logic [31:0]        r_rdata;
  logic               r_cont;
  logic               r_done, r_ovf;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               w_wr_addr, w_wr_status, w_wr_ctrl;
  logic               w_go, w_abort;
  logic               w_done_nxt, w_ovf_nxt;
  logic [15:0]        w_fcnt16;
  logic [31:0]        w_rdata;
  logic [31:0]        w_ctrl_rd;
  logic               w_unused_wdata;

  assign w_wr_addr   = avs_s1_write && (avs_s1_address == OFS_ADDR);
  assign w_wr_status = avs_s1_write && (avs_s1_address == OFS_STATUS);
  assign w_wr_ctrl   = avs_s1_write && (avs_s1_address == OFS_CONTROL);
  assign w_go        = w_wr_ctrl && avs_s1_writedata[CT_GO];
  assign w_abort     = w_wr_ctrl && avs_s1_writedata[CT_ABORT];

  // Most write-data bits are don't-care for this block.
  assign w_unused_wdata = ^avs_s1_writedata;

  // Sticky flags: a same-cycle set wins over the W1C clear.
  assign w_done_nxt = (r_state == S_DONE) ||
                      (r_done && !(w_wr_status && avs_s1_writedata[ST_DONE]));
  assign w_ovf_nxt  = cap_ovf ||
                      (r_ovf && !(w_wr_status && avs_s1_writedata[ST_OVF]));

  // Sequencer state register.
  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // Next-state and engine strobes; ABORT in the same write as GO keeps us idle.
  always_comb begin
    w_state_nxt = r_state;
    cap_start   = 1'b0;
    cap_abort   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_go && !w_abort) w_state_nxt = S_ARM;
      S_ARM: begin
        cap_start   = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cap_done)     w_state_nxt = S_DONE;
        else if (w_abort) w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = r_cont ? S_ARM : S_IDLE;
      S_DRAIN: begin
        cap_abort = 1'b1;
        if (!cap_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file, frame counter and the frame address latched on entry to ARM.
  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      r_addr     <= '0;
      r_cont     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_fcnt     <= '0;
      r_cap_addr <= '0;
    end else begin
      if (w_wr_addr) r_addr <= avs_s1_writedata;
      if (w_wr_ctrl) r_cont <= avs_s1_writedata[CT_CONT];
      r_done <= w_done_nxt;
      r_ovf  <= w_ovf_nxt;
      if (r_state == S_DONE)     r_fcnt     <= r_fcnt + 1'b1;
      if (w_state_nxt == S_ARM)  r_cap_addr <= r_addr;
    end
  end

  assign cap_addr = r_cap_addr;
  assign w_fcnt16 = 16'(r_fcnt);

`ifdef CAMERA_CTRL_IRQ_EN
  logic r_irq_en, w_irq_en_nxt, r_irq;

  assign w_irq_en_nxt = w_wr_ctrl ? avs_s1_writedata[CT_IRQ_EN] : r_irq_en;
  assign w_ctrl_rd    = {29'd0, r_irq_en, r_cont, 1'b0};

  // Interrupt enable and registered level interrupt tracking the sticky flags.
  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_irq_en_nxt && (w_done_nxt || w_ovf_nxt);
    end
  end

  assign irq = r_irq;
`else
  assign w_ctrl_rd = {30'd0, r_cont, 1'b0};
  assign irq       = 1'b0;
`endif

  // Read mux uses current register values, so read+write at one offset sees old data.
  always_comb begin
    w_rdata = '0;
    case (avs_s1_address)
      OFS_ADDR:    w_rdata = r_addr;
      OFS_STATUS:  w_rdata = {w_fcnt16, 13'd0, r_ovf, r_done, (r_state != S_IDLE)};
      OFS_CONTROL: w_rdata = w_ctrl_rd;
      OFS_VERSION: w_rdata = VERSION;
      default:     w_rdata = '0;
    endcase
  end

  // Registered read data, one cycle after the read strobe.
  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n)  r_rdata <= '0;
    else if (avs_s1_read) r_rdata <= w_rdata;
    else                  r_rdata <= '0;
  end

  assign avs_s1_readdata = r_rdata;

endmodule
